// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the five-stage CPU pipeline (PC -> IFD -> DE -> EM -> MWB).
// Holds the sequencing FSM state encoding and the register-file constants
// used by the pipeline registers and the hazard controller.
package cpu_pipe_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned NUM_REGS    = 26;
    localparam int unsigned SPECIAL_REG = 25;
    // PipeIFD loads this word when it is flushed.
    localparam logic [31:0] NOP_INSTR   = 32'h0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
//   master : datapath side - drives decode sources, per-stage destinations,
//            write enables and branch_taken; receives enables/flush/bubble,
//            performance counters and debug state.
//   slave  : controller side - the mirror image of master.
interface pipeline_hazard_ctrl_if
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned CNT_W  = 16
);

    logic [ADDR_W-1:0] dec_rs_a;
    logic [ADDR_W-1:0] dec_rs_b;
    logic              dec_use_a;
    logic              dec_use_b;
    logic [ADDR_W-1:0] de_dst;
    logic [ADDR_W-1:0] em_dst;
    logic [ADDR_W-1:0] wb_dst;
    logic              de_wr;
    logic              em_wr;
    logic              wb_wr;
    logic              branch_taken;

    logic              pc_en;
    logic              ifd_en;
    logic              ifd_flush;
    logic              de_bubble;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [1:0]        state;

    modport master (
        output dec_rs_a, dec_rs_b, dec_use_a, dec_use_b,
        output de_dst, em_dst, wb_dst, de_wr, em_wr, wb_wr, branch_taken,
        input  pc_en, ifd_en, ifd_flush, de_bubble, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  dec_rs_a, dec_rs_b, dec_use_a, dec_use_b,
        input  de_dst, em_dst, wb_dst, de_wr, em_wr, wb_wr, branch_taken,
        output pc_en, ifd_en, ifd_flush, de_bubble, stall_cnt, flush_cnt, state
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Read-after-write hazard detector: compares both decode source addresses
// against the destinations of the DE, EM and WB writer stages (six compares).
// Ports:
//   dec_rs_a/b, dec_use_a/b : decode sources and whether each is really read
//   de/em/wb_dst, de/em/wb_wr : writer destinations and write enables
//   hazard                  : any live source matches any live writer
// Address 0 is compared like any other register. WB is included because the
// register bank writes on the edge while decode reads combinationally.
module hazard_detect
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] dec_rs_a,
    input  logic [ADDR_W-1:0] dec_rs_b,
    input  logic              dec_use_a,
    input  logic              dec_use_b,
    input  logic [ADDR_W-1:0] de_dst,
    input  logic [ADDR_W-1:0] em_dst,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic              de_wr,
    input  logic              em_wr,
    input  logic              wb_wr,
    output logic              hazard
);

    logic hit_a;
    logic hit_b;

    always_comb begin
        hit_a = (de_wr && (dec_rs_a == de_dst)) ||
                (em_wr && (dec_rs_a == em_dst)) ||
                (wb_wr && (dec_rs_a == wb_dst));
        hit_b = (de_wr && (dec_rs_b == de_dst)) ||
                (em_wr && (dec_rs_b == em_dst)) ||
                (wb_wr && (dec_rs_b == wb_dst));
        hazard = (dec_use_a && hit_a) || (dec_use_b && hit_b);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller. Stalls PC/IFD and bubbles DE on a RAW
// hazard, flushes IFD for BRANCH_BUBBLES cycles after a taken branch, and
// keeps saturating counts of stall and flush cycles.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   hz       : slave side of pipeline_hazard_ctrl_if (decode/writer info in,
//              pc_en/ifd_en/ifd_flush/de_bubble, counters and state out)
// While rst is high the outputs force NOPs into IFD and DE.
module pipeline_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W         = REG_ADDR_W,
    parameter int unsigned BRANCH_BUBBLES = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int unsigned FC_W = (BRANCH_BUBBLES > 1) ? $clog2(BRANCH_BUBBLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(BRANCH_BUBBLES - 1);

    pipe_state_t       state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              hazard;
    logic              pc_en, ifd_en, ifd_flush, de_bubble, stall_hit;

    hazard_detect #(
        .ADDR_W (ADDR_W)
    ) u_hazard_detect (
        .dec_rs_a  (hz.dec_rs_a),
        .dec_rs_b  (hz.dec_rs_b),
        .dec_use_a (hz.dec_use_a),
        .dec_use_b (hz.dec_use_b),
        .de_dst    (hz.de_dst),
        .em_dst    (hz.em_dst),
        .wb_dst    (hz.wb_dst),
        .de_wr     (hz.de_wr),
        .em_wr     (hz.em_wr),
        .wb_wr     (hz.wb_wr),
        .hazard    (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // STALL with the hazard gone behaves exactly like RUN, so both share
    // one branch; the taken branch is then serviced in that same cycle.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            RUN, STALL: begin
                if (hazard) begin
                    state_d = STALL;
                end else if (hz.branch_taken) begin
                    fcnt_d  = FC_LOAD;
                    state_d = (BRANCH_BUBBLES > 1) ? FLUSH : RUN;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // The branch cycle itself is the first flushed slot, so
                // FLUSH lasts BRANCH_BUBBLES-1 cycles.
                if (fcnt_q <= FC_W'(1)) begin
                    fcnt_d  = '0;
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: begin
                fcnt_d  = '0;
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_en     = 1'b1;
        ifd_en    = 1'b1;
        ifd_flush = 1'b0;
        de_bubble = 1'b0;
        stall_hit = 1'b0;
        if (rst) begin
            pc_en     = 1'b0;
            ifd_en    = 1'b0;
            ifd_flush = 1'b1;
            de_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN, STALL: begin
                    if (hazard) begin
                        pc_en     = 1'b0;
                        ifd_en    = 1'b0;
                        de_bubble = 1'b1;
                        stall_hit = 1'b1;
                    end else if (hz.branch_taken) begin
                        ifd_flush = 1'b1;
                    end
                end
                FLUSH: begin
                    ifd_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_hit && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ifd_flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.pc_en     = pc_en;
    assign hz.ifd_en    = ifd_en;
    assign hz.ifd_flush = ifd_flush;
    assign hz.de_bubble = de_bubble;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
    assign hz.state     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle hazard
// vectors checked in RUN, then sequences for stall length, branch flush,
// hazard+branch priority, counter saturation and reset during FLUSH.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .ADDR_W         (ADDR_W),
        .BRANCH_BUBBLES (2),
        .CNT_W          (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus.slave)
    );

    typedef struct {
        logic [4:0] rs_a;
        logic [4:0] rs_b;
        logic       ua;
        logic       ub;
        logic [4:0] de_d;
        logic [4:0] em_d;
        logic [4:0] wb_d;
        logic       de_w;
        logic       em_w;
        logic       wb_w;
        logic       br;
        logic       exp_haz;
        logic       exp_flush;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.dec_rs_a     = '0;
        bus.dec_rs_b     = '0;
        bus.dec_use_a    = 1'b0;
        bus.dec_use_b    = 1'b0;
        bus.de_dst       = '0;
        bus.em_dst       = '0;
        bus.wb_dst       = '0;
        bus.de_wr        = 1'b0;
        bus.em_wr        = 1'b0;
        bus.wb_wr        = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pc_en"},     32'(bus.pc_en),     0);
        chk({tag, " ifd_en"},    32'(bus.ifd_en),    0);
        chk({tag, " ifd_flush"}, 32'(bus.ifd_flush), 1);
        chk({tag, " de_bubble"}, 32'(bus.de_bubble), 1);
        chk({tag, " state"},     32'(bus.state),     0);
        chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 0);
        chk({tag, " flush_cnt"}, 32'(bus.flush_cnt), 0);
    endtask

    initial begin
        int unsigned bubbles;

        //             rs_a   rs_b   ua    ub    de_d   em_d   wb_d   dew   emw   wbw   br    haz   flush
        vecs[0]  = '{5'd3,  5'd4,  1'b1, 1'b1, 5'd3,  5'd4,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{5'd3,  5'd9,  1'b1, 1'b1, 5'd3,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{5'd5,  5'd9,  1'b1, 1'b1, 5'd1,  5'd5,  5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{5'd6,  5'd9,  1'b1, 1'b1, 5'd1,  5'd2,  5'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{5'd1,  5'd12, 1'b1, 1'b1, 5'd12, 5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{5'd1,  5'd7,  1'b1, 1'b0, 5'd2,  5'd7,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{5'd1,  5'd7,  1'b1, 1'b1, 5'd2,  5'd7,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{5'd1,  5'd25, 1'b1, 1'b1, 5'd2,  5'd3,  5'd25, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{5'd0,  5'd1,  1'b1, 1'b1, 5'd0,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{5'd3,  5'd4,  1'b0, 1'b1, 5'd3,  5'd5,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{5'd3,  5'd4,  1'b1, 1'b1, 5'd5,  5'd6,  5'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{5'd3,  5'd4,  1'b1, 1'b1, 5'd3,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{5'd31, 5'd30, 1'b1, 1'b1, 5'd29, 5'd28, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{5'd0,  5'd7,  1'b0, 1'b1, 5'd2,  5'd7,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        idle();
        #1;
        chk_reset_outputs("initial reset");
        pulse_reset();

        // Vectors are applied after the falling edge and withdrawn before the
        // rising edge, so the FSM stays in RUN and only the comb path is seen.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.dec_rs_a     = vecs[i].rs_a;
            bus.dec_rs_b     = vecs[i].rs_b;
            bus.dec_use_a    = vecs[i].ua;
            bus.dec_use_b    = vecs[i].ub;
            bus.de_dst       = vecs[i].de_d;
            bus.em_dst       = vecs[i].em_d;
            bus.wb_dst       = vecs[i].wb_d;
            bus.de_wr        = vecs[i].de_w;
            bus.em_wr        = vecs[i].em_w;
            bus.wb_wr        = vecs[i].wb_w;
            bus.branch_taken = vecs[i].br;
            #1;
            chk($sformatf("vec%0d pc_en", i),     32'(bus.pc_en),     32'(!vecs[i].exp_haz));
            chk($sformatf("vec%0d ifd_en", i),    32'(bus.ifd_en),    32'(!vecs[i].exp_haz));
            chk($sformatf("vec%0d de_bubble", i), 32'(bus.de_bubble), 32'(vecs[i].exp_haz));
            chk($sformatf("vec%0d ifd_flush", i), 32'(bus.ifd_flush), 32'(vecs[i].exp_flush));
            idle();
        end
        @(negedge clk);
        chk("vectors stall_cnt", 32'(bus.stall_cnt), 0);
        chk("vectors state", 32'(bus.state), 0);

        // DE-stage RAW: writer moves DE -> EM -> WB, one stage per cycle.
        pulse_reset();
        bubbles = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle();
            bus.dec_rs_a  = 5'd3;
            bus.dec_use_a = 1'b1;
            if (i == 0) begin bus.de_dst = 5'd3; bus.de_wr = 1'b1; end
            if (i == 1) begin bus.em_dst = 5'd3; bus.em_wr = 1'b1; end
            if (i == 2) begin bus.wb_dst = 5'd3; bus.wb_wr = 1'b1; end
            #1;
            if (bus.de_bubble && !bus.pc_en) bubbles++;
            if (i == 1) chk("raw mid state", 32'(bus.state), 1);
        end
        @(negedge clk);
        chk("raw stall cycles", bubbles, 3);
        chk("raw stall_cnt", 32'(bus.stall_cnt), 3);
        chk("raw final state", 32'(bus.state), 0);
        idle();

        // Taken branch: two flushed slots; a branch during FLUSH is ignored.
        pulse_reset();
        @(negedge clk);
        bus.branch_taken = 1'b1;
        #1;
        chk("br cyc1 ifd_flush", 32'(bus.ifd_flush), 1);
        chk("br cyc1 pc_en", 32'(bus.pc_en), 1);
        chk("br cyc1 ifd_en", 32'(bus.ifd_en), 1);
        @(negedge clk);
        #1;
        chk("br cyc2 state", 32'(bus.state), 2);
        chk("br cyc2 ifd_flush", 32'(bus.ifd_flush), 1);
        chk("br cyc2 pc_en", 32'(bus.pc_en), 1);
        @(negedge clk);
        bus.branch_taken = 1'b0;
        #1;
        chk("br after state", 32'(bus.state), 0);
        chk("br after ifd_flush", 32'(bus.ifd_flush), 0);
        chk("br flush_cnt", 32'(bus.flush_cnt), 2);

        // Hazard on WB special register coinciding with a taken branch.
        pulse_reset();
        @(negedge clk);
        bus.wb_dst = 5'd25; bus.wb_wr = 1'b1;
        bus.dec_rs_b = 5'd25; bus.dec_use_b = 1'b1;
        bus.branch_taken = 1'b1;
        #1;
        chk("hzbr c1 de_bubble", 32'(bus.de_bubble), 1);
        chk("hzbr c1 ifd_flush", 32'(bus.ifd_flush), 0);
        @(negedge clk);
        bus.wb_wr = 1'b0;
        #1;
        chk("hzbr c2 state", 32'(bus.state), 1);
        chk("hzbr c2 ifd_flush", 32'(bus.ifd_flush), 1);
        chk("hzbr c2 pc_en", 32'(bus.pc_en), 1);
        chk("hzbr c2 de_bubble", 32'(bus.de_bubble), 0);
        @(negedge clk);
        bus.branch_taken = 1'b0;
        #1;
        chk("hzbr c3 state", 32'(bus.state), 2);
        chk("hzbr c3 ifd_flush", 32'(bus.ifd_flush), 1);
        @(negedge clk);
        #1;
        chk("hzbr end state", 32'(bus.state), 0);
        chk("hzbr stall_cnt", 32'(bus.stall_cnt), 1);
        chk("hzbr flush_cnt", 32'(bus.flush_cnt), 2);

        // Saturation of the 4-bit stall counter.
        pulse_reset();
        @(negedge clk);
        bus.dec_rs_a = 5'd9; bus.dec_use_a = 1'b1;
        bus.de_dst = 5'd9; bus.de_wr = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat stall_cnt", 32'(bus.stall_cnt), 15);
        chk("sat state", 32'(bus.state), 1);

        // Hazard clears with a branch pending, then reset lands in FLUSH.
        idle();
        bus.branch_taken = 1'b1;
        #1;
        chk("stall->br ifd_flush", 32'(bus.ifd_flush), 1);
        @(negedge clk);
        bus.branch_taken = 1'b0;
        #1;
        chk("pre-rst state", 32'(bus.state), 2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid-flush reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst ifd_flush", 32'(bus.ifd_flush), 0);
        chk("post-rst state", 32'(bus.state), 0);
        @(negedge clk);
        #1;
        chk("post-rst edge1 state", 32'(bus.state), 0);
        chk("post-rst edge1 ifd_flush", 32'(bus.ifd_flush), 0);
        chk("post-rst flush_cnt", 32'(bus.flush_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage CPU pipeline (PC → IFD → DE → EM → MWB). It detects read-after-write hazards between the decode stage and the three downstream writer stages, and stalls fetch/decode while injecting bubbles into DE. It also squashes wrong-path fetches after a taken branch. It sits beside ControlUnit and drives enable/flush inputs on PC, PipeIFD and PipeDE, plus two saturating performance counters.

## Interface
- `ADDR_W`, 5: register address width.
- `BRANCH_BUBBLES`, 2: IFD flush cycles per taken branch, ≥1. Covers the synchronous MemInst read latency.
- `CNT_W`, 16: performance counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dec_rs_a`  in  ADDR_W  decode source A address (DirRegA).
- `dec_rs_b`  in  ADDR_W  decode source B address, after the DirB mux.
- `dec_use_a`, `dec_use_b`  in  1  source is actually read (low when muxValA/muxValB selects the immediate).
- `de_dst`, `em_dst`, `wb_dst`  in  ADDR_W  effective destination per stage (after muxDirW, so 25 for the special-register write).
- `de_wr`, `em_wr`, `wb_wr`  in  1  register-write enable per stage.
- `branch_taken`  in  1  ControlUnit PC-select (crtlMuxDireccionPC).
- `pc_en`  out  1  PC load enable.
- `ifd_en`  out  1  PipeIFD hold when low.
- `ifd_flush`  out  1  PipeIFD loads NOP.
- `de_bubble`  out  1  PipeDE loads all-zero control (WriteReg = WriteMem = 0).
- `stall_cnt`  out  CNT_W  stall cycles since reset, saturating.
- `flush_cnt`  out  CNT_W  flush cycles since reset, saturating.
- `state`  out  2  FSM state, for debug.

## Operation
- A hazard exists when either of these holds for any stage X ∈ {DE, EM, WB}:
  - `dec_use_a` is high and `X_wr` is high and `dec_rs_a == X_dst`.
  - `dec_use_b` is high and `X_wr` is high and `dec_rs_b == X_dst`.
- All 32 address codes are compared, including 0; there is no hardwired-zero exemption.
- WB is included because RegisterBank writes on the edge and decode reads combinationally, so a same-cycle write is not visible to the read. There is no forwarding.
- FSM states: RUN (0), STALL (1), FLUSH (2).
  - **RUN:**
    - Hazard → STALL outputs this cycle, next state STALL.
    - Else `branch_taken` → `pc_en`=1, `ifd_flush`=1, load the flush counter with BRANCH_BUBBLES−1. Next state is FLUSH if BRANCH_BUBBLES>1, else RUN.
    - Else all enables high, no flush, no bubble.
  - **STALL:** outputs `pc_en`=0, `ifd_en`=0, `de_bubble`=1, `ifd_flush`=0.
    - Stays in STALL while the hazard persists.
    - When the hazard clears, it behaves exactly as RUN in that same cycle, including servicing `branch_taken`.
  - **FLUSH:** `pc_en`=1, `ifd_en`=1, `ifd_flush`=1, `de_bubble`=0.
    - The counter decrements each cycle; at 0 the next state is RUN.
    - `branch_taken` and the hazard are ignored, because decode holds a NOP.
- Priority when hazard and `branch_taken` coincide: stall wins. The branch is re-evaluated once the hazard clears.
- `stall_cnt` increments in every cycle with `de_bubble`=1 caused by a hazard.
- `flush_cnt` increments in every cycle with `ifd_flush`=1 outside reset.
- Both counters hold at 2^CNT_W−1.

## Timing
- Hazard detection and all enable/flush outputs are combinational from the current inputs and registered state, with zero-cycle latency. The state and counters are registered.
- While `rst` is high, asynchronously:
  - state = RUN, flush counter = 0, `stall_cnt` = `flush_cnt` = 0.
  - `pc_en`=0, `ifd_en`=0, `ifd_flush`=1, `de_bubble`=1, so the pipeline fills with NOPs.
- After `rst` falls, the first edge runs normally.
- A RAW on a DE-stage writer costs 3 stall cycles; on an EM writer, 2; on a WB writer, 1.
- A taken branch costs exactly BRANCH_BUBBLES flushed IFD slots.
- `rst` asserted mid-STALL or mid-FLUSH returns the FSM to RUN immediately. No flush is carried over.

## Structure
- Shared package `cpu_pipe_pkg` holds:
  - the state enum {RUN, STALL, FLUSH};
  - `REG_ADDR_W` = 5;
  - `NUM_REGS` = 26;
  - `SPECIAL_REG` = 25;
  - `NOP_INSTR` = 32'h0, used by PipeIFD on flush.
- One combinational sub-module, `hazard_detect`: the six-way address comparator producing the `hazard` signal.
- The FSM, flush counter and performance counters live in the top level.

## Test plan
- **Reset:** assert `rst` mid-run → immediately `pc_en`=0, `ifd_en`=0, `ifd_flush`=1, `de_bubble`=1, `state`=0, both counters 0.
- **DE-stage RAW:**
  - Stimulus: `dec_rs_a`=3, `dec_use_a`=1, `de_dst`=3, `de_wr`=1, then the writer advances to EM, then WB, one stage per cycle.
  - Required: exactly 3 cycles with `pc_en`=0 and `de_bubble`=1, then RUN, with `stall_cnt`=3.
- **Immediate source:** `dec_use_b`=0 with `dec_rs_b`=`em_dst`=7 and `em_wr`=1 → no stall. Same case with `em_wr`=0 → no stall.
- **Taken branch, BRANCH_BUBBLES=2:**
  - Stimulus: `branch_taken` pulse in RUN.
  - Required: `ifd_flush`=1 for 2 cycles with `pc_en`=1, `flush_cnt`=2.
  - A `branch_taken` asserted during the FLUSH cycle is ignored.
- **Hazard plus branch, same cycle:**
  - Stimulus: `wb_dst`=25, `wb_wr`=1, `dec_rs_b`=25, `dec_use_b`=1, `branch_taken`=1.
  - Required: 1 stall cycle, then the flush sequence starts in the next cycle.
- **Saturation and reset mid-flush:**
  - With CNT_W=4, 20 consecutive hazard cycles → `stall_cnt`=15.
  - `rst` pulsed during FLUSH → `state`=RUN and `ifd_flush` not asserted on the first cycle after release.
